// File: rtl/ntt_loop_controller_pkg.sv
// Shared constants and types for the 128-point mixed-radix NTT loop controller.
// Holds the transform geometry, the 2-bit FSM state encodings (also used by the
// address generator's instantiating top), and a helper that computes the butterfly
// span of a stage.
package ntt_loop_controller_pkg;

  localparam int unsigned N              = 128;
  localparam int unsigned LOG_N          = 7;
  localparam int unsigned NUM_STAGES     = 4;
  localparam int unsigned BFLY_PER_STAGE = 32;

  typedef logic [3:0] stage_t;
  typedef logic [4:0] idx_t;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_GAP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam stage_t LAST_STAGE = 4'(NUM_STAGES - 1);
  localparam idx_t   LAST_BFLY  = 5'(BFLY_PER_STAGE - 1);

  // Span of stage p is 4^p. Only meaningful for p < 3; stage 3 does not use it.
  function automatic logic [5:0] stage_span(stage_t p);
    return 6'd1 << (p << 1);
  endfunction

endpackage

// File: rtl/ntt_loop_controller_if.sv
// Handshake/tuple bundle between the NTT loop controller and its consumer.
//   start      : begin a transform (sampled only when idle)
//   bf_ready   : consumer accepts the current tuple this cycle
//   valid      : p/k/j/i carry a valid tuple
//   p,k,j,i    : stage, group, in-group and in-stage butterfly indices
//   stage_last : current tuple is the last butterfly of its stage
//   busy       : transform in progress
//   done       : one-cycle pulse after the final tuple is accepted
// master = controller side, slave = consumer/requester side.
interface ntt_loop_controller_if;
  import ntt_loop_controller_pkg::*;

  logic   start;
  logic   bf_ready;
  logic   valid;
  stage_t p;
  idx_t   k;
  idx_t   j;
  idx_t   i;
  logic   stage_last;
  logic   busy;
  logic   done;

  modport master (
    input  start, bf_ready,
    output valid, p, k, j, i, stage_last, busy, done
  );

  modport slave (
    output start, bf_ready,
    input  valid, p, k, j, i, stage_last, busy, done
  );
endinterface

// File: rtl/ntt_loop_controller.sv
// Loop/sequence controller feeding the address generator of a 128-point NTT.
// On start it walks 4 stages of 32 radix-4 butterflies and presents one
// (p,k,j,i) tuple per accepted cycle, optionally idling STAGE_GAP cycles between
// stages so the butterfly pipeline drains. done pulses after the last tuple.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : ntt_loop_controller_if.master (start/bf_ready in; tuple, busy, done out)
// All outputs come straight from registers.
module ntt_loop_controller
  import ntt_loop_controller_pkg::*;
#(
  parameter int unsigned STAGE_GAP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ntt_loop_controller_if.master  bus
);

  // Gap counter preload: GAP lasts load+1 cycles.
  localparam logic [3:0] GAP_LOAD = 4'(STAGE_GAP - 1);

  state_t     state_q, state_d;
  stage_t     p_q, p_d;
  idx_t       k_q, k_d;
  idx_t       j_q, j_d;
  idx_t       i_q, i_d;
  logic [3:0] gap_q, gap_d;

  logic       accept;
  logic       last;
  logic [5:0] span_m1;

  assign accept  = (state_q == ST_RUN) && bus.bf_ready;
  assign last    = (i_q == LAST_BFLY);
  assign span_m1 = stage_span(p_q) - 6'd1;

  // FSM next state and gap down-counter.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (accept && last) begin
          if (p_q == LAST_STAGE) begin
            state_d = ST_DONE;
          end else if (STAGE_GAP != 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_RUN;
        else               gap_d   = gap_q - 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Index counters: j inner, k outer for p<3; only i counts in stage 3.
  always_comb begin
    p_d = p_q;
    k_d = k_q;
    j_d = j_q;
    i_d = i_q;
    if (state_q == ST_IDLE && bus.start) begin
      p_d = '0;
      k_d = '0;
      j_d = '0;
      i_d = '0;
    end else if (accept) begin
      if (last) begin
        k_d = '0;
        j_d = '0;
        i_d = '0;
        // Return p to 0 after the final stage so DONE/IDLE present a zero tuple.
        p_d = (p_q == LAST_STAGE) ? '0 : p_q + 4'd1;
      end else begin
        i_d = i_q + 5'd1;
        if (p_q != LAST_STAGE) begin
          if ({1'b0, j_q} == span_m1) begin
            j_d = '0;
            k_d = k_q + 5'd1;
          end else begin
            j_d = j_q + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q <= '0;
      k_q <= '0;
      j_q <= '0;
      i_q <= '0;
    end else begin
      p_q <= p_d;
      k_q <= k_d;
      j_q <= j_d;
      i_q <= i_d;
    end
  end

  assign bus.valid      = (state_q == ST_RUN);
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.stage_last = (state_q == ST_RUN) && last;
  assign bus.p          = p_q;
  assign bus.k          = k_q;
  assign bus.j          = j_q;
  assign bus.i          = i_q;

endmodule

// File: tb/tb_ntt_loop_controller.sv
module tb_ntt_loop_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ntt_loop_controller_if bus4 ();
  ntt_loop_controller_if bus0 ();

  ntt_loop_controller #(.STAGE_GAP(4)) dut_g4 (.clk(clk), .rst(rst), .bus(bus4));
  ntt_loop_controller #(.STAGE_GAP(0)) dut_g0 (.clk(clk), .rst(rst), .bus(bus0));

  // Hand-computed (p,i) -> (k,j) tuples.
  int ht_p [7] = '{1, 1, 1, 1, 1, 2, 3};
  int ht_i [7] = '{0, 1, 3, 4, 31, 17, 31};
  int ht_k [7] = '{0, 0, 0, 1, 7, 1, 0};
  int ht_j [7] = '{0, 1, 3, 0, 3, 1, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus4.valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0 ||
        bus4.stage_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl_g4: valid=%b busy=%b done=%b last=%b want 0000",
               bus4.valid, bus4.busy, bus4.done, bus4.stage_last);
    end
    checks++;
    if (bus4.p !== 4'd0 || bus4.k !== 5'd0 || bus4.j !== 5'd0 || bus4.i !== 5'd0) begin
      errors++;
      $display("FAIL reset_idx_g4: p=%0d k=%0d j=%0d i=%0d want 0", bus4.p, bus4.k, bus4.j, bus4.i);
    end
    checks++;
    if (bus0.valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.i !== 5'd0) begin
      errors++;
      $display("FAIL reset_g0: valid=%b busy=%b done=%b i=%0d want 0", bus0.valid, bus0.busy,
               bus0.done, bus0.i);
    end
    rst = 1'b1;
    tick();
  endtask

  // Full gap-4 run with cycle-exact expectations; cycle 1 is the first after start.
  task automatic test_full_run(input bit poke_start);
    int tuples = 0;
    int dones  = 0;
    int base;
    bit ev;
    int ep;
    int ei;
    bus4.bf_ready = 1'b1;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      if (poke_start) bus4.start = (c == 50 || c == 141);
      ev = (c >= 1 && c <= 32) || (c >= 37 && c <= 68) || (c >= 73 && c <= 104) ||
           (c >= 109 && c <= 140);
      ep = (c <= 32) ? 0 : (c <= 68) ? 1 : (c <= 104) ? 2 : 3;
      base = (ep == 0) ? 1 : (ep == 1) ? 37 : (ep == 2) ? 73 : 109;
      ei = ev ? c - base : 0;
      checks++;
      if (bus4.valid !== ev) begin
        errors++;
        $display("FAIL run_valid c=%0d: got %b want %b", c, bus4.valid, ev);
      end
      checks++;
      if (bus4.done !== (c == 141)) begin
        errors++;
        $display("FAIL run_done c=%0d: got %b want %b", c, bus4.done, (c == 141));
      end
      checks++;
      if (bus4.busy !== (c <= 140)) begin
        errors++;
        $display("FAIL run_busy c=%0d: got %b want %b", c, bus4.busy, (c <= 140));
      end
      if (c <= 140) begin
        checks++;
        if (bus4.p !== 4'(ep) || bus4.i !== 5'(ei)) begin
          errors++;
          $display("FAIL run_pi c=%0d: got p=%0d i=%0d want p=%0d i=%0d", c, bus4.p, bus4.i, ep, ei);
        end
        checks++;
        if (bus4.stage_last !== (ev && ei == 31)) begin
          errors++;
          $display("FAIL run_last c=%0d: got %b want %b", c, bus4.stage_last, (ev && ei == 31));
        end
        checks++;
        if (ep < 3 && ev) begin
          if ((32'(bus4.k) << (2 * ep)) + 32'(bus4.j) != ei || 32'(bus4.j) >= (1 << (2 * ep))) begin
            errors++;
            $display("FAIL run_invariant c=%0d: p=%0d i=%0d k=%0d j=%0d", c, ep, ei, bus4.k, bus4.j);
          end
        end else if (bus4.k !== 5'd0 || bus4.j !== 5'd0) begin
          errors++;
          $display("FAIL run_kj_zero c=%0d: got k=%0d j=%0d want 0 0", c, bus4.k, bus4.j);
        end
        for (int h = 0; h < 7; h++) begin
          if (ev && ep == ht_p[h] && ei == ht_i[h]) begin
            checks++;
            if (bus4.k !== 5'(ht_k[h]) || bus4.j !== 5'(ht_j[h])) begin
              errors++;
              $display("FAIL tuple p=%0d i=%0d: got k=%0d j=%0d want k=%0d j=%0d", ep, ei,
                       bus4.k, bus4.j, ht_k[h], ht_j[h]);
            end
          end
        end
      end
      if (bus4.valid === 1'b1 && bus4.bf_ready) tuples++;
      if (bus4.done === 1'b1) dones++;
      tick();
    end
    bus4.start = 1'b0;
    checks++;
    if (tuples != 128 || dones != 1) begin
      errors++;
      $display("FAIL run_totals: tuples=%0d dones=%0d want 128 1", tuples, dones);
    end
  endtask

  task automatic test_gap0();
    int tuples = 0;
    bit ev;
    bus0.bf_ready = 1'b1;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int c = 1; c <= 135; c++) begin
      ev = (c <= 128);
      checks++;
      if (bus0.valid !== ev || bus0.done !== (c == 129)) begin
        errors++;
        $display("FAIL gap0_ctrl c=%0d: got valid=%b done=%b want %b %b", c, bus0.valid,
                 bus0.done, ev, (c == 129));
      end
      if (ev) begin
        checks++;
        if (bus0.p !== 4'((c - 1) / 32) || bus0.i !== 5'((c - 1) % 32)) begin
          errors++;
          $display("FAIL gap0_pi c=%0d: got p=%0d i=%0d want p=%0d i=%0d", c, bus0.p, bus0.i,
                   (c - 1) / 32, (c - 1) % 32);
        end
        tuples++;
      end
      tick();
    end
    checks++;
    if (tuples != 128) begin
      errors++;
      $display("FAIL gap0_tuples: got %0d want 128", tuples);
    end
  endtask

  task automatic test_backpressure();
    int  accepts = 0;
    int  dones   = 0;
    bit  found   = 1'b0;
    bus4.bf_ready = 1'b1;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (bus4.valid === 1'b1 && bus4.p === 4'd2 && bus4.i === 5'd5) found = 1'b1;
      else begin
        if (bus4.valid === 1'b1) accepts++;
        tick();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bp_reach: got found=0 want p=2 i=5 within 200 cycles");
    end
    bus4.bf_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (bus4.valid !== 1'b1 || bus4.p !== 4'd2 || bus4.k !== 5'd0 || bus4.j !== 5'd5 ||
          bus4.i !== 5'd5) begin
        errors++;
        $display("FAIL bp_hold n=%0d: got v=%b p=%0d k=%0d j=%0d i=%0d want 1 2 0 5 5", n,
                 bus4.valid, bus4.p, bus4.k, bus4.j, bus4.i);
      end
      tick();
    end
    bus4.bf_ready = 1'b1;
    for (int n = 0; n < 300 && dones == 0; n++) begin
      if (bus4.valid === 1'b1) begin
        checks++;
        if (bus4.p !== 4'(accepts / 32) || bus4.i !== 5'(accepts % 32)) begin
          errors++;
          $display("FAIL bp_seq #%0d: got p=%0d i=%0d want p=%0d i=%0d", accepts, bus4.p,
                   bus4.i, accepts / 32, accepts % 32);
        end
        accepts++;
      end
      if (bus4.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (accepts != 128 || dones != 1) begin
      errors++;
      $display("FAIL bp_totals: accepts=%0d dones=%0d want 128 1", accepts, dones);
    end
  endtask

  task automatic test_reset_midrun();
    bit found = 1'b0;
    bus4.bf_ready = 1'b1;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (bus4.valid === 1'b1 && bus4.p === 4'd1 && bus4.i === 5'd10) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_reach: got found=0 want p=1 i=10 within 100 cycles");
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (bus4.valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.p !== 4'd0 ||
        bus4.k !== 5'd0 || bus4.j !== 5'd0 || bus4.i !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b b=%b d=%b p=%0d k=%0d j=%0d i=%0d want all 0",
               bus4.valid, bus4.busy, bus4.done, bus4.p, bus4.k, bus4.j, bus4.i);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (bus4.done !== 1'b0 || bus4.valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_quiet n=%0d: got done=%b valid=%b want 0 0", n, bus4.done, bus4.valid);
      end
    end
    test_full_run(1'b0);
  endtask

  task automatic test_start_ignored();
    test_full_run(1'b1);
  endtask

  initial begin
    rst = 1'b0;
    bus4.start = 1'b0;
    bus0.start = 1'b0;
    bus4.bf_ready = 1'b1;
    bus0.bf_ready = 1'b1;
    test_reset();
    test_full_run(1'b0);
    test_gap0();
    test_backpressure();
    test_reset_midrun();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
